riscv_dmem_resp: RTL and testbench

//  Data-memory responder on the far side of the dmem interface driven by the MEM stage.

---
 rtl/riscv_dmem_resp.sv | 134 +++++++++++++
 tb/tb_riscv_dmem_resp.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/riscv_dmem_resp.sv
// riscv_dmem_resp: word-wide data RAM responder behind the MEM-stage dmem port.
// One request per handshake, strobed writes, full-word reads, WAIT_CYCLES wait states.
// Optional feature macro: RISCV_DMEM_ERR_EN (misaligned / out-of-range error reporting).
module riscv_dmem_resp #(
    parameter int                  XLEN        = 32,
    parameter int                  DEPTH_WORDS = 1024,
    parameter int                  WAIT_CYCLES = 0,
    parameter logic [XLEN-1:0]     BASE_ADDR   = '0
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_dmem_req,
    input  logic [XLEN-1:0] i_dmem_addr,
    input  logic            i_dmem_wen,
    input  logic [XLEN-1:0] i_dmem_wr_data,
    input  logic [3:0]      i_dmem_byte_sel,
    output logic            o_dmem_ready,
    output logic            o_dmem_rvalid,
    output logic [XLEN-1:0] o_dmem_rd_data,
    output logic            o_dmem_err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic            wen;
        logic [XLEN-1:0] wdata;
        logic [3:0]      be;
    } req_t;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    req_t            req_q, req_in, cur;
    logic [XLEN-1:0] rd_q;
    logic            err_q, err_d;
    logic            accept, commit;
    logic [XLEN-1:0] off;
    logic [AW-1:0]   idx;

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    // Pack the port request; in IDLE the live request is the one being
    // committed (zero-wait case), afterwards the latched copy is used.
    always_comb begin
        req_in.addr  = i_dmem_addr;
        req_in.wen   = i_dmem_wen;
        req_in.wdata = i_dmem_wr_data;
        req_in.be    = i_dmem_byte_sel;
        cur          = (state_q == S_IDLE) ? req_in : req_q;
        off          = cur.addr - BASE_ADDR;
        idx          = off[AW+1:2];
    end

`ifdef RISCV_DMEM_ERR_EN
    // Misaligned, or outside the window (below BASE wraps to a huge offset).
    always_comb begin
        err_d = (cur.addr[1:0] != 2'b00) || ((off >> (AW + 2)) != '0);
    end
`else
    // No error reporting: low address bits ignored, high bits wrap.
    always_comb begin
        err_d = 1'b0;
    end
    logic unused_addr_bits;
    assign unused_addr_bits = ^{off[XLEN-1:AW+2], off[1:0]};
`endif

    // Next-state and handshake: IDLE -> (WAIT) -> RESP -> IDLE.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        o_dmem_ready = 1'b0;
        accept       = 1'b0;
        commit       = 1'b0;
        case (state_q)
            S_IDLE: begin
                o_dmem_ready = 1'b1;
                if (i_dmem_req) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES);
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control state, latched request and registered response; data/err
    // are cleared on every edge that does not enter RESP.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) req_q <= req_in;
            rd_q    <= (commit && !cur.wen && !err_d) ? mem[idx] : '0;
            err_q   <= commit && err_d;
        end
    end

    // Array is never reset; a write lands only on the edge entering RESP.
    always_ff @(posedge i_clk) begin
        if (commit && i_rstn && cur.wen && !err_d) begin
            for (int b = 0; b < 4; b++) begin
                if (cur.be[b]) mem[idx][8*b +: 8] <= cur.wdata[8*b +: 8];
            end
        end
    end

    assign o_dmem_rvalid  = (state_q == S_RESP);
    assign o_dmem_rd_data = rd_q;
    assign o_dmem_err     = err_q;

endmodule

// File: tb/tb_riscv_dmem_resp.sv
// Scoreboard bench: instance 0 has no wait states, instance 1 has three.
module tb_riscv_dmem_resp;
    localparam int          W0    = 0;
    localparam int          W1    = 3;
    localparam int          DEPTH = 64;
    localparam logic [31:0] B1    = 32'h0000_2000;
`ifdef RISCV_DMEM_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]        req, wen, ready, rvalid, err;
    logic [1:0][31:0]  addr, wdata, rd;
    logic [1:0][3:0]   be;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    riscv_dmem_resp #(.XLEN(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W0), .BASE_ADDR(32'h0)) u_dut0 (
        .i_clk(clk), .i_rstn(rstn), .i_dmem_req(req[0]), .i_dmem_addr(addr[0]),
        .i_dmem_wen(wen[0]), .i_dmem_wr_data(wdata[0]), .i_dmem_byte_sel(be[0]),
        .o_dmem_ready(ready[0]), .o_dmem_rvalid(rvalid[0]), .o_dmem_rd_data(rd[0]),
        .o_dmem_err(err[0]));

    riscv_dmem_resp #(.XLEN(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W1), .BASE_ADDR(B1)) u_dut1 (
        .i_clk(clk), .i_rstn(rstn), .i_dmem_req(req[1]), .i_dmem_addr(addr[1]),
        .i_dmem_wen(wen[1]), .i_dmem_wr_data(wdata[1]), .i_dmem_byte_sel(be[1]),
        .o_dmem_ready(ready[1]), .o_dmem_rvalid(rvalid[1]), .o_dmem_rd_data(rd[1]),
        .o_dmem_err(err[1]));

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          c;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pop and compare on every response, else outputs must be quiet.
    task automatic mon(input int k);
        exp_t e;
        int   n;
        n = (k == 0) ? q0.size() : q1.size();
        if (rvalid[k]) begin
            if (n == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rvalid%0d: got rvalid=1 expected no response", k);
            end else begin
                if (k == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk($sformatf("rdata%0d", k), rd[k], e.d);
                chk($sformatf("err%0d", k), 32'(err[k]), 32'(e.e));
                chk($sformatf("latency%0d", k), 32'(cyc), 32'(e.c));
            end
        end else begin
            chk($sformatf("idle_out%0d", k), rd[k] | 32'(err[k]), 32'h0);
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            mon(0);
            mon(1);
        end
    end

    // Present a request, hold it until accepted, push the expected response.
    task automatic do_req(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b, input logic [31:0] ed, input logic ee,
                          output int acc, output int nwait);
        exp_t e;
        @(negedge clk);
        req[k] = 1'b1; wen[k] = w; addr[k] = a; wdata[k] = d; be[k] = b;
        nwait = 0;
        while (!ready[k] && nwait < 50) begin
            @(negedge clk);
            nwait++;
        end
        if (!ready[k]) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout%0d: got ready=0 expected ready=1 within 50 cycles", k);
            req[k] = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clk);
        #1;
        acc    = cyc;
        req[k] = 1'b0;
        e.d = ed;
        e.e = ee;
        e.c = acc + ((k == 0) ? W0 : W1);
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic rq(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b, input logic [31:0] ed, input logic ee);
        int acc, nw;
        do_req(k, w, a, d, b, ed, ee, acc, nw);
    endtask

    task automatic drain(input int k);
        int n;
        n = 0;
        while (((k == 0) ? q0.size() : q1.size()) != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (((k == 0) ? q0.size() : q1.size()) != 0) begin
            checks++;
            errors++;
            $display("FAIL drain%0d: got pending responses expected none after 50 cycles", k);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, nw;
        req = '0; wen = '0; addr = '0; wdata = '0; be = '0;

        // Power-up reset
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("por_ready0", 32'(ready[0]), 32'h1);
        chk("por_ready1", 32'(ready[1]), 32'h1);

        // Reset held with a pending write request: nothing is written
        rq(0, 1'b1, 32'h40, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0);
        drain(0);
        @(negedge clk);
        rstn = 1'b0;
        req[0] = 1'b1; wen[0] = 1'b1; addr[0] = 32'h40; wdata[0] = 32'h1234_5678; be[0] = 4'hF;
        repeat (3) @(negedge clk);
        req[0] = 1'b0;
        rstn   = 1'b1;
        #1;
        chk("rst_ready", 32'(ready[0]), 32'h1);
        chk("rst_rvalid", 32'(rvalid[0]), 32'h0);
        chk("rst_rdata", rd[0], 32'h0);
        rq(0, 1'b0, 32'h40, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0);

        // Zero wait states: write then read back
        rq(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
        rq(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);

        // Byte strobes, back-to-back accepts every 2 cycles
        rq(0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, 32'h0, 1'b0);
        do_req(0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0, a0, nw);
        do_req(0, 1'b0, 32'h20, 32'h0, 4'hF, 32'h11BB_33DD, 1'b0, a1, nw);
        chk("b2b_spacing0", 32'(a1 - a0), 32'd2);
        rq(0, 1'b1, 32'h24, 32'h7777_7777, 4'b0000, 32'h0, 1'b0);
        rq(0, 1'b0, 32'h24, 32'h0, 4'h0, 32'h0, 1'b0);
        rq(0, 1'b1, 32'h24, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0);
        rq(0, 1'b0, 32'h24, 32'h0, 4'h0, 32'h0, 1'b0);
        drain(0);

        // Three wait states: held request blocked during WAIT/RESP
        do_req(1, 1'b1, B1 + 32'h30, 32'h0, 4'hF, 32'h0, 1'b0, a0, nw);
        do_req(1, 1'b0, B1 + 32'h30, 32'h0, 4'h0, 32'h0, 1'b0, a1, nw);
        chk("b2b_spacing1", 32'(a1 - a0), 32'd5);
        chk("ready_low_cycles1", 32'(nw), 32'd4);
        rq(1, 1'b1, B1 + 32'h34, 32'hA5A5_0F0F, 4'hF, 32'h0, 1'b0);
        rq(1, 1'b0, B1 + 32'h34, 32'h0, 4'h0, 32'hA5A5_0F0F, 1'b0);
        drain(1);

        // Reset in the middle of WAIT drops the accepted write
        rq(1, 1'b1, B1 + 32'h30, 32'h0000_0055, 4'hF, 32'h0, 1'b0);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        q1.delete();
        rstn = 1'b1;
        #1;
        chk("midwait_rvalid", 32'(rvalid[1]), 32'h0);
        chk("midwait_ready", 32'(ready[1]), 32'h1);
        rq(1, 1'b0, B1 + 32'h30, 32'h0, 4'h0, 32'h0, 1'b0);
        drain(1);

        // Misaligned and out-of-range addresses
        rq(0, 1'b1, 32'h0, 32'h0102_0304, 4'hF, 32'h0, 1'b0);
        rq(0, 1'b1, 32'h13, 32'h9999_9999, 4'hF, 32'h0, ERR);
        rq(0, 1'b0, 32'h10, 32'h0, 4'h0, ERR ? 32'hDEAD_BEEF : 32'h9999_9999, 1'b0);
        rq(0, 1'b0, 32'(4 * DEPTH), 32'h0, 4'h0, ERR ? 32'h0 : 32'h0102_0304, ERR);
        rq(1, 1'b1, B1 + 32'h8, 32'h1357_9BDF, 4'hF, 32'h0, 1'b0);
        rq(1, 1'b0, B1 + 32'(4 * DEPTH) + 32'h8, 32'h0, 4'h0, ERR ? 32'h0 : 32'h1357_9BDF, ERR);
        drain(0);
        drain(1);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
